// File: rtl/wb_stage.sv
// wb_stage: write-back controller driving the register file write port from ALU results or extended memory loads.
module wb_stage #(
  parameter int RWIDTH       = 6,
  parameter int DWIDTH       = 32,
  parameter int ZERO_PROTECT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic              in_src,
  input  logic [RWIDTH-1:0] in_rd,
  input  logic [DWIDTH-1:0] in_alu_res,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic              mem_rvalid,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [RWIDTH-1:0] wa,
  output logic [DWIDTH-1:0] wd,
  output logic              we,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;
  localparam logic ZP = (ZERO_PROTECT != 0);
  state_t              r_state, w_next;
  logic [RWIDTH-1:0]   r_rd, r_wa;
  logic [DWIDTH-1:0]   r_wd, w_ext;
  logic [1:0]          r_size, r_off;
  logic                r_uns, r_wen;
  logic                w_accept, w_eff_wen, w_sgn;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  assign w_accept  = in_valid & (r_state == IDLE);
  assign w_eff_wen = in_wen & ~(ZP & (in_rd == '0));
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = (r_state == IDLE)     ? (w_accept ? (in_src ? WAIT_MEM : (w_eff_wen ? WRITE : IDLE)) : IDLE)
           : (r_state == WAIT_MEM) ? (mem_rvalid ? (r_wen ? WRITE : IDLE) : WAIT_MEM)
           : IDLE;
  end
  always_comb begin
    in_ready = (r_state == IDLE);
    busy     = (r_state != IDLE);
    we       = (r_state == WRITE);
    wa       = r_wa;
    wd       = r_wd;
  end
  // Half selection ignores off[0]: misaligned halves read the aligned lane.
  always_comb begin
    w_byte = mem_rdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_sgn  = ~r_uns & (r_size == 2'b00 ? w_byte[7] : w_half[15]);
    w_ext  = (r_size == 2'b00) ? {{(DWIDTH-8){w_sgn}}, w_byte}
           : (r_size == 2'b01) ? {{(DWIDTH-16){w_sgn}}, w_half}
           : mem_rdata;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_wa   <= '0;
      r_wd   <= '0;
      r_rd   <= '0;
      r_size <= '0;
      r_off  <= '0;
      r_uns  <= 1'b0;
      r_wen  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd   <= in_rd;
        r_size <= in_size;
        r_uns  <= in_unsigned;
        r_wen  <= w_eff_wen;
        r_off  <= in_alu_res[1:0];
      end
      if (w_accept && !in_src && w_eff_wen) begin
        r_wa <= in_rd;
        r_wd <= in_alu_res;
      end else if (r_state == WAIT_MEM && mem_rvalid && r_wen) begin
        r_wa <= r_rd;
        r_wd <= w_ext;
      end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven and randomized checks of wb_stage against a byte/half/word extraction model.
module tb_wb_stage;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_wen = 0, in_src = 0, in_unsigned = 0, mem_rvalid = 0;
  logic        in_ready, we, busy;
  logic [5:0]  in_rd = 0, wa;
  logic [31:0] in_alu_res = 0, mem_rdata = 0, wd;
  logic [1:0]  in_size = 0;
  int checks = 0, errors = 0;
  wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_src(in_src), .in_rd(in_rd), .in_alu_res(in_alu_res), .in_size(in_size),
    .in_unsigned(in_unsigned), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wa(wa), .wd(wd), .we(we), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        src, wen, uns;
    logic [5:0]  rd;
    logic [31:0] alu, rdata;
    logic [1:0]  size;
    int          delay, exp_n;
    logic [31:0] exp_wd;
  } vec_t;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask
  function automatic vec_t mk(logic src, logic wen, logic [5:0] rd, logic [31:0] alu, logic [1:0] size,
                              logic uns, logic [31:0] rdata, int delay, int exp_n, logic [31:0] exp_wd);
    vec_t v;
    v.src = src; v.wen = wen; v.rd = rd; v.alu = alu; v.size = size; v.uns = uns;
    v.rdata = rdata; v.delay = delay; v.exp_n = exp_n; v.exp_wd = exp_wd;
    return v;
  endfunction
  // Reference: one write iff enabled and rd nonzero; loads pick a lane by shifting and extend arithmetically.
  function automatic void model(inout vec_t v);
    logic [31:0] a, lane;
    int off;
    a = v.alu;
    off = int'(a[1:0]);
    v.exp_n = (v.wen && v.rd != 0) ? 1 : 0;
    if (!v.src) v.exp_wd = v.alu;
    else if (v.size == 2'd0) begin
      lane = (v.rdata >> (8 * off)) & 32'hFF;
      v.exp_wd = (!v.uns && lane >= 128) ? lane + 32'hFFFFFF00 : lane;
    end else if (v.size == 2'd1) begin
      lane = (v.rdata >> (off >= 2 ? 16 : 0)) & 32'hFFFF;
      v.exp_wd = (!v.uns && lane >= 32768) ? lane + 32'hFFFF0000 : lane;
    end else v.exp_wd = v.rdata;
  endfunction
  task automatic do_txn(input vec_t v, input string nm);
    int pulses = 0, at = -1, busy_bad = 0;
    logic [5:0] lwa = 0;
    logic [31:0] lwd = 0;
    @(negedge clk);
    in_valid = 1; in_src = v.src; in_wen = v.wen; in_rd = v.rd; in_alu_res = v.alu;
    in_size = v.size; in_unsigned = v.uns;
    @(negedge clk);
    in_valid = 0;
    for (int c = 0; c < v.delay + 5; c++) begin
      if (we) begin pulses++; lwa = wa; lwd = wd; if (at < 0) at = c; end
      if (v.src && c <= v.delay && !busy) busy_bad++;
      mem_rvalid = v.src && (c == v.delay);
      mem_rdata  = v.rdata;
      @(negedge clk);
    end
    mem_rvalid = 0;
    check({nm, " pulses"}, pulses, v.exp_n);
    check({nm, " busy_wait"}, busy_bad, 0);
    check({nm, " ready_after"}, {31'b0, in_ready}, 1);
    if (v.exp_n == 1) begin
      check({nm, " latency"}, at, v.src ? v.delay + 1 : 0);
      check({nm, " wa"}, {26'b0, lwa}, {26'b0, v.rd});
      check({nm, " wd"}, lwd, v.exp_wd);
    end
  endtask
  vec_t tbl[11];
  vec_t rv;
  initial begin
    tbl[0]  = mk(0, 1, 6'd5,  32'hDEADBEEF, 2'd2, 0, 32'h0,        0, 1, 32'hDEADBEEF);
    tbl[1]  = mk(1, 1, 6'd7,  32'h00001002, 2'd0, 0, 32'h12803456, 3, 1, 32'hFFFFFF80);
    tbl[2]  = mk(1, 1, 6'd9,  32'h00002002, 2'd1, 1, 32'hBEEF1234, 2, 1, 32'h0000BEEF);
    tbl[3]  = mk(1, 1, 6'd9,  32'h00002002, 2'd1, 0, 32'hBEEF1234, 0, 1, 32'hFFFFBEEF);
    tbl[4]  = mk(0, 1, 6'd0,  32'h11111111, 2'd2, 0, 32'h0,        0, 0, 32'h0);
    tbl[5]  = mk(1, 1, 6'd0,  32'h00000000, 2'd2, 0, 32'h55555555, 2, 0, 32'h0);
    tbl[6]  = mk(0, 0, 6'd3,  32'h22222222, 2'd2, 0, 32'h0,        0, 0, 32'h0);
    tbl[7]  = mk(1, 1, 6'd12, 32'h00000003, 2'd0, 1, 32'hA5000000, 1, 1, 32'h000000A5);
    tbl[8]  = mk(1, 1, 6'd13, 32'h00000003, 2'd0, 0, 32'hA5000000, 4, 1, 32'hFFFFFFA5);
    tbl[9]  = mk(1, 1, 6'd14, 32'h00000001, 2'd3, 0, 32'h80000001, 1, 1, 32'h80000001);
    tbl[10] = mk(1, 1, 6'd15, 32'h00000001, 2'd1, 0, 32'h00008001, 0, 1, 32'hFFFF8001);
    repeat (2) @(negedge clk);
    rst = 0;
    check("reset we", {31'b0, we}, 0);
    check("reset wa", {26'b0, wa}, 0);
    check("reset wd", wd, 0);
    check("reset busy", {31'b0, busy}, 0);
    check("reset ready", {31'b0, in_ready}, 1);
    foreach (tbl[i]) do_txn(tbl[i], $sformatf("vec%0d", i));
    // load with write enable cleared: response consumed without a write
    do_txn(mk(1, 0, 6'd4, 32'h0, 2'd2, 0, 32'hFFFFFFFF, 1, 0, 32'h0), "load_nowen");
    // two queued ALU ops with in_valid held high: accepts two cycles apart
    @(negedge clk);
    in_valid = 1; in_src = 0; in_wen = 1; in_rd = 6'd21; in_alu_res = 32'hAAAA0001;
    @(negedge clk);
    check("b2b first we", {31'b0, we}, 1);
    check("b2b first wa", {26'b0, wa}, 21);
    check("b2b ready low", {31'b0, in_ready}, 0);
    in_rd = 6'd22; in_alu_res = 32'hBBBB0002;
    @(negedge clk);
    check("b2b gap we", {31'b0, we}, 0);
    @(negedge clk);
    in_valid = 0;
    check("b2b second we", {31'b0, we}, 1);
    check("b2b second wa", {26'b0, wa}, 22);
    check("b2b second wd", wd, 32'hBBBB0002);
    @(negedge clk);
    check("b2b end we", {31'b0, we}, 0);
    // stray rvalid in IDLE
    mem_rvalid = 1; mem_rdata = 32'h99999999;
    @(negedge clk);
    mem_rvalid = 0;
    check("idle rvalid we", {31'b0, we}, 0);
    check("idle rvalid busy", {31'b0, busy}, 0);
    @(negedge clk);
    check("idle rvalid we2", {31'b0, we}, 0);
    check("idle rvalid wd held", wd, 32'hBBBB0002);
    // reset in the middle of a load
    in_valid = 1; in_src = 1; in_wen = 1; in_rd = 6'd30; in_alu_res = 32'h0; in_size = 2'd2;
    @(negedge clk);
    in_valid = 0;
    check("midload busy", {31'b0, busy}, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midload ready", {31'b0, in_ready}, 1);
    mem_rvalid = 1; mem_rdata = 32'h77777777;
    @(negedge clk);
    mem_rvalid = 0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("midload we c%0d", c), {31'b0, we}, 0);
      @(negedge clk);
    end
    check("midload busy after", {31'b0, busy}, 0);
    // randomized transactions against the model
    for (int n = 0; n < 60; n++) begin
      rv.src = 1'($urandom_range(0, 1));
      rv.wen = ($urandom_range(0, 7) != 0);
      rv.rd = 6'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 63));
      rv.alu = $urandom;
      rv.size = 2'($urandom_range(0, 3));
      rv.uns = 1'($urandom_range(0, 1));
      rv.rdata = $urandom;
      rv.delay = $urandom_range(0, 5);
      model(rv);
      do_txn(rv, $sformatf("rnd%0d", n));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
